slave_select_queue: RTL and testbench
=====================================

Name: slave_select_queue

Overview:
- Buffers slave-select write addresses produced by the AXI write manager (`wrSlaveAddr` qualified by the one-cycle `wr_en` pulse).
- Presents them in order to the SPI transaction engine over a valid/ready handshake.
- Feeds `SSQ_full` back to the write manager, which uses it to return SLVERR on BRESP when the queue cannot accept another entry.
- Synchronous FIFO with first-word fall-through output, occupancy count and sticky overflow flag.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of 2 and at least 2.
- AW, 8, width of a queued slave address.
- AFULL_MARGIN, 1, free-slot margin used only when SSQ_AFULL_EN is defined; must be less than DEPTH.

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push strobe; each cycle it is high requests one push.
- wrSlaveAddr  in  AW  address pushed when wr_en=1.
- ss_addr  out  AW  head-of-queue address; valid while ss_valid=1.
- ss_valid  out  1  queue non-empty; head entry is presented.
- ss_ready  in  1  consumer accepts the head entry when ss_valid=1 and ss_ready=1.
- SSQ_full  out  1  queue cannot accept a push without a same-cycle pop.
- SSQ_empty  out  1  occupancy = 0.
- ssq_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ssq_ovf  out  1  sticky: a push was dropped.
- ovf_clr  in  1  synchronous clear of ssq_ovf.

Behaviour:
- Storage: DEPTH x AW register array; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH; occupancy is held in ssq_count.
- reset low (asynchronous, any cycle, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, ssq_count=0, ssq_ovf=0.
  - Outputs: ss_valid=0, SSQ_empty=1, SSQ_full=0, ss_addr=0.
  - Array contents are don't-care.
  - Any entries held at reset are lost.
- pop = ss_valid & ss_ready. push_ok = wr_en & (~full_int | pop).
  - full_int means ssq_count==DEPTH.
- Push: mem[wr_ptr] <= wrSlaveAddr; wr_ptr++.
- Pop: rd_ptr++.
- Count: +1 on push_ok only, -1 on pop only, unchanged when both or neither occur.
- Latency:
  - Push in cycle N makes the entry visible on ss_valid/ss_addr in cycle N+1. There is no combinational path from wr_en to ss_valid.
  - A pop in cycle N presents the next entry in cycle N+1.
- Outputs:
  - ss_addr = mem[rd_ptr] (fall-through), forced to 0 when empty.
  - ss_valid = (ssq_count!=0); SSQ_empty = ~ss_valid.
  - All outputs are derived from registers only.
- Empty plus simultaneous wr_en and ss_ready: push only; no pop occurs because ss_valid=0.
- Full plus simultaneous wr_en and pop: both are performed; count stays at DEPTH and ordering is preserved.
- Full plus wr_en with no pop:
  - Push is dropped; pointers and count are unchanged.
  - ssq_ovf <= 1 next cycle.
- ovf_clr: ssq_ovf <= 0. If an overflow occurs in the same cycle, set wins and ssq_ovf stays 1.
- ss_ready while empty: ignored.
- ss_addr must hold stable while ss_valid=1 and ss_ready=0, even across pushes.

Optional Feature:
- Macro: SSQ_AFULL_EN.
- Defined: SSQ_full = (ssq_count >= DEPTH-AFULL_MARGIN).
  - Gives the write manager early back-pressure to cover its registered decision latency.
  - Pushes are still accepted until the true full_int condition; overflow and drop rules are unchanged.
- Not defined: SSQ_full = full_int, i.e. ssq_count==DEPTH.
  - AFULL_MARGIN is unused.

Test Plan:
1. Reset, then push 0x02,0x04,0x06 on consecutive cycles with ss_ready=0 -> ss_valid=1 from the cycle after the first push; ss_addr=0x02; ssq_count=3. Then hold ss_ready=1 -> ss_addr sequence 0x02,0x04,0x06, then ss_valid=0, SSQ_empty=1, ssq_count=0.
2. DEPTH=8, ss_ready=0, push 0x00..0x0E (8 pushes) -> SSQ_full=1, ssq_count=8. 9th push of 0x0C -> dropped; ssq_ovf=1; drained data is the original 8 in order. Pulse ovf_clr -> ssq_ovf=0.
3. Full queue, wr_en=1 with 0x0A plus ss_ready=1 in the same cycle -> count stays 8, head advances, and 0x0A is drained last.
4. Empty queue, wr_en=1 with 0x08 plus ss_ready=1 -> no pop; next cycle ss_valid=1, ss_addr=0x08, ssq_count=1.
5. Queue holding 5 entries, drive reset low mid-drain for a partial cycle -> all outputs return to reset values immediately (asynchronously); after release, the first push 0x04 is presented alone.
6. SSQ_AFULL_EN defined with AFULL_MARGIN=1 -> SSQ_full=1 at count 7. 8th push accepted, count=8, ssq_ovf=0. 9th push dropped, ssq_ovf=1.

Source files
------------

// File: rtl/slave_select_queue.sv
// Slave-select address queue: FWFT FIFO between the AXI write manager and the SPI engine.
// Optional macro SSQ_AFULL_EN raises SSQ_full early, AFULL_MARGIN slots before the queue is truly full.
module slave_select_queue #(
    parameter int DEPTH        = 8,
    parameter int AW           = 8,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                       ACLK,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wrSlaveAddr,
    output logic [AW-1:0]              ss_addr,
    output logic                       ss_valid,
    input  logic                       ss_ready,
    output logic                       SSQ_full,
    output logic                       SSQ_empty,
    output logic [$clog2(DEPTH):0]     ssq_count,
    output logic                       ssq_ovf,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_MARGIN >= DEPTH || AFULL_MARGIN < 0)
    begin : g_bad_params
        $error("slave_select_queue: illegal DEPTH/AFULL_MARGIN combination");
    end

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full_int;
    logic          pop;
    logic          push_ok;
    logic          overflow;

    assign full_int = (ssq_count == CW'(DEPTH));
    assign pop      = ss_valid & ss_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok  = wr_en & (~full_int | pop);
    assign overflow = wr_en & full_int & ~pop;

    // Storage carries no reset; stale contents are masked by ss_valid.
    always_ff @(posedge ACLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wrSlaveAddr;
        end
    end

    always_ff @(posedge ACLK or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ssq_count <= '0;
            ssq_ovf   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   ssq_count <= ssq_count + 1'b1;
                2'b01:   ssq_count <= ssq_count - 1'b1;
                default: ssq_count <= ssq_count;
            endcase
            // Set wins over a simultaneous clear so no drop goes unreported.
            if (overflow) begin
                ssq_ovf <= 1'b1;
            end else if (ovf_clr) begin
                ssq_ovf <= 1'b0;
            end
        end
    end

    assign ss_valid  = (ssq_count != '0);
    assign SSQ_empty = ~ss_valid;
    assign ss_addr   = ss_valid ? mem[rd_ptr] : '0;

`ifdef SSQ_AFULL_EN
    assign SSQ_full = (ssq_count >= CW'(DEPTH - AFULL_MARGIN));
`else
    assign SSQ_full = full_int;
`endif

endmodule

// File: tb/tb_slave_select_queue.sv
// Randomized and directed bench for slave_select_queue with a queue-based reference model.
// Build with +define+SSQ_AFULL_EN to exercise the early-full variant.
module tb_slave_select_queue;

    localparam int DEPTH        = 8;
    localparam int AW           = 8;
    localparam int AFULL_MARGIN = 1;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic          ACLK = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wrSlaveAddr;
    logic [AW-1:0] ss_addr;
    logic          ss_valid;
    logic          ss_ready;
    logic          SSQ_full;
    logic          SSQ_empty;
    logic [CW-1:0] ssq_count;
    logic          ssq_ovf;
    logic          ovf_clr;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [AW-1:0] exp_q[$];
    int            model_count;
    logic          model_ovf;

    slave_select_queue #(
        .DEPTH(DEPTH),
        .AW(AW),
        .AFULL_MARGIN(AFULL_MARGIN)
    ) dut (
        .ACLK(ACLK),
        .reset(reset),
        .wr_en(wr_en),
        .wrSlaveAddr(wrSlaveAddr),
        .ss_addr(ss_addr),
        .ss_valid(ss_valid),
        .ss_ready(ss_ready),
        .SSQ_full(SSQ_full),
        .SSQ_empty(SSQ_empty),
        .ssq_count(ssq_count),
        .ssq_ovf(ssq_ovf),
        .ovf_clr(ovf_clr)
    );

    // Clock / reset
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic model_full(input int cnt);
`ifdef SSQ_AFULL_EN
        return cnt >= DEPTH - AFULL_MARGIN;
`else
        return cnt == DEPTH;
`endif
    endfunction

    // Reference model: a plain FIFO of expected addresses and an occupancy integer.
    always @(posedge ACLK or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            model_count = 0;
            model_ovf   = 1'b0;
        end else begin
            logic do_pop;
            logic do_push;
            do_pop  = (model_count > 0) && ss_ready;
            do_push = wr_en && ((model_count < DEPTH) || do_pop);
            if (do_push) exp_q.push_back(wrSlaveAddr);
            model_count = model_count + int'(do_push) - int'(do_pop);
            if (wr_en && !do_push) model_ovf = 1'b1;
            else if (ovf_clr)      model_ovf = 1'b0;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each handshake.
    always @(negedge ACLK) begin
        check("ssq_count", 32'(ssq_count), 32'(model_count));
        check("ss_valid", 32'(ss_valid), 32'(model_count != 0));
        check("SSQ_empty", 32'(SSQ_empty), 32'(model_count == 0));
        check("SSQ_full", 32'(SSQ_full), 32'(model_full(model_count)));
        check("ssq_ovf", 32'(ssq_ovf), 32'(model_ovf));
        if (ss_valid) begin
            if (exp_q.size() == 0) begin
                check("ss_valid_unexpected", 32'(ss_valid), 32'd0);
            end else begin
                check("ss_addr", 32'(ss_addr), 32'(exp_q[0]));
                if (ss_ready) void'(exp_q.pop_front());
            end
        end else begin
            check("ss_addr_idle", 32'(ss_addr), 32'd0);
        end
    end

    // Driver: apply inputs just after an edge, return 1 time unit after the next edge.
    task automatic step(input logic we, input logic [AW-1:0] a, input logic rdy, input logic clr);
        wr_en       = we;
        wrSlaveAddr = a;
        ss_ready    = rdy;
        ovf_clr     = clr;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        wr_en       = 1'b0;
        wrSlaveAddr = '0;
        ss_ready    = 1'b0;
        ovf_clr     = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_count", 32'(ssq_count), 32'd0);
        check("rst_empty", 32'(SSQ_empty), 32'd1);
        check("rst_addr", 32'(ss_addr), 32'd0);
        reset = 1'b1;
        idle();

        // In-order push then drain
        step(1'b1, 8'h02, 1'b0, 1'b0);
        check("t1_valid_after_first", 32'(ss_valid), 32'd1);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        step(1'b1, 8'h06, 1'b0, 1'b0);
        check("t1_head", 32'(ss_addr), 32'h02);
        check("t1_count", 32'(ssq_count), 32'd3);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        check("t1_drained_valid", 32'(ss_valid), 32'd0);
        check("t1_drained_empty", 32'(SSQ_empty), 32'd1);

        // Fill to full, overflow, set-wins, clear, then full push+pop
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
`ifdef SSQ_AFULL_EN
                check("t6_afull_at_7", 32'(SSQ_full), 32'd1);
`else
                check("t2_not_full_at_7", 32'(SSQ_full), 32'd0);
`endif
            end
            step(1'b1, 8'(2 * i), 1'b0, 1'b0);
        end
        check("t2_full", 32'(SSQ_full), 32'd1);
        check("t2_count", 32'(ssq_count), 32'(DEPTH));
        check("t2_no_ovf_yet", 32'(ssq_ovf), 32'd0);
        step(1'b1, 8'h0C, 1'b0, 1'b0);
        check("t2_ovf", 32'(ssq_ovf), 32'd1);
        check("t2_count_after_drop", 32'(ssq_count), 32'(DEPTH));
        step(1'b1, 8'h0C, 1'b0, 1'b1);
        check("t2_set_wins", 32'(ssq_ovf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t2_ovf_clr", 32'(ssq_ovf), 32'd0);
        step(1'b1, 8'h0A, 1'b1, 1'b0);
        check("t3_count_kept", 32'(ssq_count), 32'(DEPTH));
        check("t3_head_advanced", 32'(ss_addr), 32'h02);
        check("t3_no_ovf", 32'(ssq_ovf), 32'd0);
        repeat (DEPTH - 1) step(1'b0, '0, 1'b1, 1'b0);
        check("t3_last_is_new", 32'(ss_addr), 32'h0A);
        step(1'b0, '0, 1'b1, 1'b0);

        // Empty with push and ready together: push only
        step(1'b1, 8'h08, 1'b1, 1'b0);
        check("t4_valid", 32'(ss_valid), 32'd1);
        check("t4_addr", 32'(ss_addr), 32'h08);
        check("t4_count", 32'(ssq_count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("t5_async_valid", 32'(ss_valid), 32'd0);
        check("t5_async_count", 32'(ssq_count), 32'd0);
        check("t5_async_addr", 32'(ss_addr), 32'd0);
        check("t5_async_empty", 32'(SSQ_empty), 32'd1);
        #3 reset = 1'b1;
        @(posedge ACLK);
        #1;
        step(1'b1, 8'h04, 1'b0, 1'b0);
        check("t5_alone_addr", 32'(ss_addr), 32'h04);
        check("t5_alone_count", 32'(ssq_count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
        end
        repeat (DEPTH + 2) step(1'b0, '0, 1'b1, 1'b0);
        check("final_empty", 32'(SSQ_empty), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
